// File: rtl/sub_16bits_seq.sv
// sub_16bits_seq: multi-cycle subtractor, diff = a - b - b_in.
// One SLICE-bit chunk is resolved per clock, LSB chunk first, with the
// borrow rippling between chunks through a register. Handshake is
// start / busy / done. The results only change on the edge that raises done.
// Optional feature: define SUB_ADD_MODE_EN to add an "op" input
// (op=1 adds a + b + b_in and reports the carry on b_out).
module sub_16bits_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
`ifdef SUB_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_brw;      // borrow (or carry) into the current chunk
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shadow;   // partial result, committed to diff at the end
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_op;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE:0]   w_res;
    logic [WIDTH-1:0] w_shadow_nx;
    logic             w_last;
    logic             w_add;
    logic             w_ovf;

    // Chunk datapath: one SLICE-bit add/subtract plus the merged shadow value
    always_comb begin
        w_a_sl      = r_a[int'(r_cnt)*SLICE +: SLICE];
        w_b_sl      = r_b[int'(r_cnt)*SLICE +: SLICE];
        w_add       = r_op;
        if (w_add)
            w_res = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_brw};
        else
            w_res = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{SLICE{1'b0}}, r_brw};
        w_shadow_nx = r_shadow;
        w_shadow_nx[int'(r_cnt)*SLICE +: SLICE] = w_res[SLICE-1:0];
        w_last      = (r_cnt == CW'(NSLICE - 1));
        if (w_add)
            w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_shadow_nx[WIDTH-1] != r_a[WIDTH-1]);
        else
            w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_shadow_nx[WIDTH-1] != r_a[WIDTH-1]);
    end

    // Control FSM, operand capture and per-slice result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_brw    <= 1'b0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_op     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE accepts a new start exactly like IDLE
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_brw   <= b_in;
`ifdef SUB_ADD_MODE_EN
                        r_op    <= op;
`else
                        r_op    <= 1'b0;
`endif
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // start is ignored here; operands stay as captured
                    r_shadow <= w_shadow_nx;
                    r_brw    <= w_res[SLICE];
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_diff  <= w_shadow_nx;
                        r_bout  <= w_res[SLICE];
                        r_ovf   <= w_ovf;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign diff  = r_diff;
    assign b_out = r_bout;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_sub_16bits_seq.sv
// Scoreboard bench for sub_16bits_seq: the driver pushes hand-computed
// expectations, a negedge monitor pops one on every done pulse.
module tb_sub_16bits_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        bin_i = 1'b0;
    logic        op_i = 1'b0;
    logic        busy, done, b_out, ovf;
    logic [15:0] diff;

    sub_16bits_seq #(.WIDTH(16), .SLICE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .b_in  (bin_i),
`ifdef SUB_ADD_MODE_EN
        .op    (op_i),
`endif
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        int          acc;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [15:0] last_diff = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_diff"},    {16'd0, diff}, {16'd0, e.d});
                chk({e.name, "_b_out"},   {31'd0, b_out}, {31'd0, e.bo});
                chk({e.name, "_ovf"},     {31'd0, ovf}, {31'd0, e.ov});
                chk({e.name, "_latency"}, cyc - e.acc, 32'd4);
                chk({e.name, "_busy_lo"}, {31'd0, busy}, 32'd0);
            end
        end
    end

    // Issue one operation; optionally hold a bogus start on the 2nd busy cycle
    task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                          input logic bi, input logic [15:0] ed, input logic ebo,
                          input logic eov, input bit hold_bogus);
        exp_t e;
        int   n0, t;
        e.d = ed; e.bo = ebo; e.ov = eov; e.acc = cyc + 1; e.name = name;
        q.push_back(e);
        n0 = done_cnt;
        a_i = av; b_i = bv; bin_i = bi; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk({name, "_busy"}, {31'd0, busy}, 32'd1);
        chk({name, "_hold_prev"}, {16'd0, diff}, {16'd0, last_diff});
        if (hold_bogus) begin
            @(negedge clk); #1;
            a_i = 16'hFFFF; b_i = 16'h0000; bin_i = 1'b0; start = 1'b1;
        end
        t = 0;
        while (done_cnt == n0 && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        start = 1'b0;
        if (done_cnt == n0) chk({name, "_timeout"}, 32'd1, 32'd0);
        last_diff = ed;
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_diff",  {16'd0, diff},  32'd0);
        chk("rst_b_out", {31'd0, b_out}, 32'd0);
        chk("rst_ovf",   {31'd0, ovf},   32'd0);

        run_op("basic",   16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op("wrap",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_op("all_one", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("bin",     16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b1);

        // Stray start while busy must not produce a second result
        n0 = done_cnt;
        repeat (6) @(negedge clk);
        #1;
        chk("ignored_one_done", done_cnt - n0, 32'd0);
        chk("done_hold_diff", {16'd0, diff}, 32'h0FFF);

        // Abort in the middle of RUN
        n0 = done_cnt;
        a_i = 16'hAAAA; b_i = 16'h5555; bin_i = 1'b0; start = 1'b1;
        @(negedge clk); #1; start = 1'b0;
        @(negedge clk); #1; rst = 1'b1;
        @(negedge clk); #1; rst = 1'b0;
        chk("abort_busy",  {31'd0, busy},  32'd0);
        chk("abort_done",  {31'd0, done},  32'd0);
        chk("abort_diff",  {16'd0, diff},  32'd0);
        chk("abort_b_out", {31'd0, b_out}, 32'd0);
        chk("abort_ovf",   {31'd0, ovf},   32'd0);
        repeat (8) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt - n0, 32'd0);
        last_diff = 16'h0000;

`ifdef SUB_ADD_MODE_EN
        op_i = 1'b1;
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        op_i = 1'b0;
        run_op("sub_again", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
